// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller and the fetch stage.
// Contents: fetch mux select encodings and controller state encodings.
package fetch_redirect_ctrl_pkg;

  localparam logic [1:0] SEL_SEQ  = 2'b00;  // PC+4, or branch target when PCSrc=1
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_JR   = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    PEND = 2'b10
  } state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Handshake bundle between the pipeline hazard/redirect sources, the
// instruction memory ready flag and the fetch stage controls.
//   master : the pipeline side (drives hazard/redirect inputs, reads controls)
//   slave  : fetch_redirect_ctrl
interface fetch_redirect_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              br_taken_ex;
  logic [ADDR_W-1:0] br_target_ex;
  logic              jump_id;
  logic [ADDR_W-1:0] jump_target_id;
  logic              jr_id;
  logic [ADDR_W-1:0] jr_target_id;
  logic              load_use_id;
  logic              imem_ready;
  logic [1:0]        sel;
  logic              PCSrc;
  logic [ADDR_W-1:0] redir_target;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pending;

  modport master (
    output br_taken_ex, br_target_ex, jump_id, jump_target_id,
           jr_id, jr_target_id, load_use_id, imem_ready,
    input  sel, PCSrc, redir_target, pc_write, ifid_write,
           ifid_flush, idex_flush, pending
  );

  modport slave (
    input  br_taken_ex, br_target_ex, jump_id, jump_target_id,
           jr_id, jr_target_id, load_use_id, imem_ready,
    output sel, PCSrc, redir_target, pc_write, ifid_write,
           ifid_flush, idex_flush, pending
  );
endinterface

// File: rtl/fetch_redirect_ctrl_arb.sv
// fetch_redirect_arb: combinational priority arbiter for redirect sources.
// Priority: EX branch > ID jr > ID jump (the EX branch is the older instruction).
// Ports: br/jr/jump request + target in; valid, sel, pcsrc, target out.
// target is 0 when no source requests.
module fetch_redirect_arb
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              valid,
  output logic [1:0]        sel,
  output logic              pcsrc,
  output logic [ADDR_W-1:0] target
);

  always_comb begin
    valid  = 1'b0;
    sel    = SEL_SEQ;
    pcsrc  = 1'b0;
    target = '0;
    if (br_taken) begin
      valid  = 1'b1;
      pcsrc  = 1'b1;
      target = br_target;
    end else if (jr) begin
      valid  = 1'b1;
      sel    = SEL_JR;
      target = jr_target;
    end else if (jump) begin
      valid  = 1'b1;
      sel    = SEL_JUMP;
      target = jump_target;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: sequences the IF stage of the 5-stage MIPS pipeline.
// Arbitrates redirects, applies load-use stalls and imem wait states, and
// holds a redirect pending while an imem access cannot be aborted.
// Ports: Clk, Reset (sync, active-high), fr (fetch_redirect_ctrl_if.slave).
// Optional: `define FETCH_PERF_CNT_EN adds stall_cnt / flush_cnt outputs
// (saturating 32-bit counts of pc_write=0 and ifid_flush=1 cycles).
//
// state | meaning
// RUN   | fetching normally, redirects applied the cycle they appear
// WAIT  | imem access outstanding, no redirect held
// PEND  | imem access outstanding, redirect held in pend_*
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DELAY_SLOT = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  fetch_redirect_ctrl_if.slave fr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  state_e            state, state_nxt;
  logic [1:0]        pend_sel, pend_sel_nxt;
  logic              pend_pcsrc, pend_pcsrc_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;

  logic              arb_valid, arb_pcsrc;
  logic [1:0]        arb_sel;
  logic [ADDR_W-1:0] arb_target;
  logic              stall;
  logic              pc_write, ifid_flush;

  // A load-use stall holds ID, so ID jumps are not admitted; they come back next cycle.
  assign stall = fr.load_use_id & ~fr.br_taken_ex;

  fetch_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .br_taken    (fr.br_taken_ex),
    .br_target   (fr.br_target_ex),
    .jr          (fr.jr_id & ~fr.load_use_id),
    .jr_target   (fr.jr_target_id),
    .jump        (fr.jump_id & ~fr.load_use_id),
    .jump_target (fr.jump_target_id),
    .valid       (arb_valid),
    .sel         (arb_sel),
    .pcsrc       (arb_pcsrc),
    .target      (arb_target)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= RUN;
      pend_sel    <= SEL_SEQ;
      pend_pcsrc  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_sel    <= pend_sel_nxt;
      pend_pcsrc  <= pend_pcsrc_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_sel_nxt    = pend_sel;
    pend_pcsrc_nxt  = pend_pcsrc;
    pend_target_nxt = pend_target;
    fr.sel          = SEL_SEQ;
    fr.PCSrc        = 1'b0;
    fr.redir_target = '0;
    pc_write        = 1'b0;
    fr.ifid_write   = 1'b0;
    ifid_flush      = 1'b0;
    fr.idex_flush   = 1'b0;
    fr.pending      = 1'b0;

    if (Reset) begin
      ifid_flush    = 1'b1;
      fr.idex_flush = 1'b1;
    end else begin
      unique case (state)
        RUN, WAIT: begin
          if (arb_valid) begin
            fr.sel          = arb_sel;
            fr.PCSrc        = arb_pcsrc;
            fr.redir_target = arb_target;
          end
          fr.idex_flush = fr.br_taken_ex | stall;
          if (stall) begin
            // Hold IF/ID so the load-use consumer is re-decoded.
            state_nxt = fr.imem_ready ? RUN : WAIT;
          end else if (fr.imem_ready) begin
            pc_write      = 1'b1;
            fr.ifid_write = 1'b1;
            ifid_flush    = arb_valid & (fr.br_taken_ex | (DELAY_SLOT == 0));
            state_nxt     = RUN;
          end else begin
            fr.ifid_write = 1'b1;
            ifid_flush    = 1'b1;
            if (arb_valid) begin
              pend_sel_nxt    = arb_sel;
              pend_pcsrc_nxt  = arb_pcsrc;
              pend_target_nxt = arb_target;
              state_nxt       = PEND;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
        PEND: begin
          // A branch arriving now supersedes the held redirect immediately, so a
          // branch coinciding with imem_ready is applied rather than lost.
          fr.sel          = fr.br_taken_ex ? arb_sel    : pend_sel;
          fr.PCSrc        = fr.br_taken_ex ? arb_pcsrc  : pend_pcsrc;
          fr.redir_target = fr.br_taken_ex ? arb_target : pend_target;
          fr.idex_flush   = fr.br_taken_ex;
          fr.ifid_write   = 1'b1;
          ifid_flush      = 1'b1;
          if (fr.imem_ready) begin
            pc_write        = 1'b1;
            pend_sel_nxt    = SEL_SEQ;
            pend_pcsrc_nxt  = 1'b0;
            pend_target_nxt = '0;
            state_nxt       = RUN;
          end else begin
            fr.pending = 1'b1;
            if (fr.br_taken_ex) begin
              pend_sel_nxt    = arb_sel;
              pend_pcsrc_nxt  = arb_pcsrc;
              pend_target_nxt = arb_target;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign fr.pc_write   = pc_write;
  assign fr.ifid_flush = ifid_flush;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  fetch_redirect_ctrl_if #(.ADDR_W(32)) m ();
  fetch_redirect_ctrl_if #(.ADDR_W(32)) d ();

  // Delay-slot instance sees the same stimulus.
  assign d.br_taken_ex    = m.br_taken_ex;
  assign d.br_target_ex   = m.br_target_ex;
  assign d.jump_id        = m.jump_id;
  assign d.jump_target_id = m.jump_target_id;
  assign d.jr_id          = m.jr_id;
  assign d.jr_target_id   = m.jr_target_id;
  assign d.load_use_id    = m.load_use_id;
  assign d.imem_ready     = m.imem_ready;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, d_stall_cnt, d_flush_cnt;
`endif

  fetch_redirect_ctrl #(.ADDR_W(32), .DELAY_SLOT(0)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .fr    (m)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  fetch_redirect_ctrl #(.ADDR_W(32), .DELAY_SLOT(1)) u_dut_ds (
    .Clk   (Clk),
    .Reset (Reset),
    .fr    (d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt (d_stall_cnt),
    .flush_cnt (d_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    m.br_taken_ex    = 1'b0;
    m.br_target_ex   = '0;
    m.jump_id        = 1'b0;
    m.jump_target_id = '0;
    m.jr_id          = 1'b0;
    m.jr_target_id   = '0;
    m.load_use_id    = 1'b0;
    m.imem_ready     = 1'b1;
  endtask

  initial begin
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_base;
`endif
    Reset = 1'b1;
    idle();
    #1;
    chk("rst_pc_write", 32'(m.pc_write), 32'd0);
    chk("rst_ifid_flush", 32'(m.ifid_flush), 32'd1);
    chk("rst_idex_flush", 32'(m.idex_flush), 32'd1);
    tick();
    tick();
    chk("rst2_pc_write", 32'(m.pc_write), 32'd0);
    chk("rst2_ifid_write", 32'(m.ifid_write), 32'd0);

    Reset = 1'b0;
    #1;
    chk("run_pc_write", 32'(m.pc_write), 32'd1);
    chk("run_sel", 32'(m.sel), 32'(SEL_SEQ));
    chk("run_pcsrc", 32'(m.PCSrc), 32'd0);
    chk("run_ifid_flush", 32'(m.ifid_flush), 32'd0);
    tick();

    // Branch beats a same-cycle jump.
    m.br_taken_ex = 1'b1; m.br_target_ex = 32'h40;
    m.jump_id = 1'b1; m.jump_target_id = 32'h100;
    #1;
    chk("br_sel", 32'(m.sel), 32'(SEL_SEQ));
    chk("br_pcsrc", 32'(m.PCSrc), 32'd1);
    chk("br_target", m.redir_target, 32'h40);
    chk("br_ifid_flush", 32'(m.ifid_flush), 32'd1);
    chk("br_idex_flush", 32'(m.idex_flush), 32'd1);
    chk("br_ds_ifid_flush", 32'(d.ifid_flush), 32'd1);
    tick();
    idle();

    // jr beats jump.
    m.jr_id = 1'b1; m.jr_target_id = 32'h200;
    m.jump_id = 1'b1; m.jump_target_id = 32'h100;
    #1;
    chk("jr_sel", 32'(m.sel), 32'(SEL_JR));
    chk("jr_target", m.redir_target, 32'h200);
    chk("jr_idex_flush", 32'(m.idex_flush), 32'd0);
    tick();
    idle();

    // Load-use stall, alone and cancelled by a branch.
    m.load_use_id = 1'b1;
    m.jump_id = 1'b1; m.jump_target_id = 32'h100;
    #1;
    chk("lu_pc_write", 32'(m.pc_write), 32'd0);
    chk("lu_ifid_write", 32'(m.ifid_write), 32'd0);
    chk("lu_idex_flush", 32'(m.idex_flush), 32'd1);
    chk("lu_sel", 32'(m.sel), 32'(SEL_SEQ));
    m.br_taken_ex = 1'b1; m.br_target_ex = 32'h40;
    #1;
    chk("lubr_pc_write", 32'(m.pc_write), 32'd1);
    chk("lubr_ifid_flush", 32'(m.ifid_flush), 32'd1);
    chk("lubr_idex_flush", 32'(m.idex_flush), 32'd1);
    chk("lubr_target", m.redir_target, 32'h40);
    tick();
    idle();

    // jr while imem busy -> PEND for 3 cycles, applied on ready.
    m.jr_id = 1'b1; m.jr_target_id = 32'h200; m.imem_ready = 1'b0;
    #1;
    chk("pj0_pc_write", 32'(m.pc_write), 32'd0);
    chk("pj0_ifid_flush", 32'(m.ifid_flush), 32'd1);
    tick();
    m.jr_id = 1'b0; m.jr_target_id = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pj_pending", 32'(m.pending), 32'd1);
      chk("pj_pc_write", 32'(m.pc_write), 32'd0);
      chk("pj_sel", 32'(m.sel), 32'(SEL_JR));
      tick();
    end
    m.imem_ready = 1'b1;
    #1;
    chk("pja_sel", 32'(m.sel), 32'(SEL_JR));
    chk("pja_target", m.redir_target, 32'h200);
    chk("pja_pc_write", 32'(m.pc_write), 32'd1);
    chk("pja_ifid_flush", 32'(m.ifid_flush), 32'd1);
    chk("pja_pending", 32'(m.pending), 32'd0);
    tick();
    #1;
    chk("pjd_sel", 32'(m.sel), 32'(SEL_SEQ));
    chk("pjd_target", m.redir_target, 32'h0);
    chk("pjd_ifid_flush", 32'(m.ifid_flush), 32'd0);
    tick();

    // Branch during PEND overwrites the held jr.
    m.jr_id = 1'b1; m.jr_target_id = 32'h200; m.imem_ready = 1'b0;
    tick();
    idle();
    m.imem_ready = 1'b0;
    m.br_taken_ex = 1'b1; m.br_target_ex = 32'h80;
    m.jump_id = 1'b1; m.jump_target_id = 32'h100;
    #1;
    chk("pb_pending", 32'(m.pending), 32'd1);
    chk("pb_idex_flush", 32'(m.idex_flush), 32'd1);
    tick();
    idle();
    #1;
    chk("pba_sel", 32'(m.sel), 32'(SEL_SEQ));
    chk("pba_pcsrc", 32'(m.PCSrc), 32'd1);
    chk("pba_target", m.redir_target, 32'h80);
    chk("pba_pc_write", 32'(m.pc_write), 32'd1);
    tick();

    // Reset during PEND discards the held redirect.
    m.jr_id = 1'b1; m.jr_target_id = 32'h200; m.imem_ready = 1'b0;
    tick();
    idle();
    m.imem_ready = 1'b0;
    Reset = 1'b1;
    #1;
    chk("rp_pending", 32'(m.pending), 32'd0);
    chk("rp_sel", 32'(m.sel), 32'(SEL_SEQ));
    tick();
    Reset = 1'b0;
    m.imem_ready = 1'b1;
    #1;
    chk("rpr_pending", 32'(m.pending), 32'd0);
    chk("rpr_pc_write", 32'(m.pc_write), 32'd1);
    chk("rpr_target", m.redir_target, 32'h0);
    chk("rpr_ifid_flush", 32'(m.ifid_flush), 32'd0);
    tick();

    // WAIT without a redirect, then a jump on return (delay-slot compare).
    m.imem_ready = 1'b0;
    #1;
    chk("w_pc_write", 32'(m.pc_write), 32'd0);
    chk("w_ifid_write", 32'(m.ifid_write), 32'd1);
    chk("w_ifid_flush", 32'(m.ifid_flush), 32'd1);
    tick();
    #1;
    chk("w2_pending", 32'(m.pending), 32'd0);
    m.imem_ready = 1'b1;
    m.jump_id = 1'b1; m.jump_target_id = 32'h100;
    #1;
    chk("wj_sel", 32'(m.sel), 32'(SEL_JUMP));
    chk("wj_target", m.redir_target, 32'h100);
    chk("wj_ifid_flush", 32'(m.ifid_flush), 32'd1);
    chk("wj_pc_write", 32'(m.pc_write), 32'd1);
    chk("ds_sel", 32'(d.sel), 32'(SEL_JUMP));
    chk("ds_ifid_flush", 32'(d.ifid_flush), 32'd0);
    tick();
    idle();

`ifdef FETCH_PERF_CNT_EN
    #1;
    stall_base = stall_cnt;
    m.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    m.imem_ready = 1'b1;
    #1;
    chk("perf_stall_delta", stall_cnt - stall_base, 32'd3);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
